// File: rtl/mem_responder.sv
// Wait-state memory responder: fixed-latency access with
// little-endian store lane merge and bus-error flagging.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256,
  parameter int CNT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      mem [DEPTH];

  logic          accept;
  logic          fire;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   wsh;
  logic [31:0]   merged;
  logic [AW-1:0] idx;

  assign idx   = addr_q[AW+1:2];
  assign busy  = (state != IDLE);
  assign ready = (state == RESP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = WAIT;
          accept   = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          fire     = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Store data is replicated across lanes; be picks the lanes.
  always_comb begin
    bad = (addr_q[31:2] >= 30'(DEPTH));
    be  = 4'h0;
    wsh = wdata_q;
    unique case (size_q)
      2'b00: begin
        be  = 4'hf;
        bad = bad | (addr_q[1:0] != 2'b00);
      end
      2'b01: begin
        be  = addr_q[1] ? 4'hc : 4'h3;
        wsh = {2{wdata_q[15:0]}};
        bad = bad | addr_q[0];
      end
      2'b10: begin
        be  = 4'b0001 << addr_q[1:0];
        wsh = {4{wdata_q[7:0]}};
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wsh[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(LATENCY - 1);
      wr_q    <= wr;
      size_q  <= size;
      addr_q  <= addr;
      wdata_q <= wdata;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err   <= 1'b0;
      rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fire) begin
      err <= bad;
      if (!bad) begin
        if (wr_q) mem[idx] <= merged;
        else      rdata    <= mem[idx];
      end
    end
  end

endmodule
